// File: rtl/t_subtractor.sv
// Bit-serial subtractor: recovers b from c = a + b, one bit per clock, LSB first.
// Handshake: start_i is a request pulse sampled only in IDLE; done_o is a one-cycle strobe, results hold until the next completion.
module t_subtractor (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] c_i,
  input  logic [3:0] a_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] diff_o,
  output logic [3:0] b_o,
  output logic       neg_o,
  output logic       ovf_o,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] c_sh;
  logic [7:0] a_sh;
  logic [7:0] acc;
  logic [2:0] cnt;
  logic       borrow;

  logic       c_bit;
  logic       a_bit;
  logic       d_bit;
  logic       b_next;
  logic [7:0] acc_next;
  logic       ovf_next;

  // 1-bit full subtractor on the LSBs of the shifting operand registers
  assign c_bit    = c_sh[0];
  assign a_bit    = a_sh[0];
  assign d_bit    = c_bit ^ a_bit ^ borrow;
  assign b_next   = (~c_bit & a_bit) | (~(c_bit ^ a_bit) & borrow);
  assign acc_next = {d_bit, acc[7:1]};
  assign ovf_next = ~b_next & (acc_next[7:4] != 4'd0);

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      c_sh   <= 8'd0;
      a_sh   <= 8'd0;
      acc    <= 8'd0;
      cnt    <= 3'd0;
      borrow <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      diff_o <= 8'd0;
      b_o    <= 4'd0;
      neg_o  <= 1'b0;
      ovf_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            c_sh   <= c_i;
            a_sh   <= {4'd0, a_i};
            acc    <= 8'd0;
            cnt    <= 3'd0;
            borrow <= 1'b0;
            busy_o <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          c_sh   <= c_sh >> 1;
          a_sh   <= a_sh >> 1;
          acc    <= acc_next;
          borrow <= b_next;
          cnt    <= cnt + 3'd1;
          // Visible outputs are only written on the final bit, never partially
          if (cnt == 3'd7) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            diff_o <= acc_next;
            b_o    <= acc_next[3:0];
            neg_o  <= b_next;
            ovf_o  <= ovf_next;
            state  <= DONE;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          done_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t_subtractor.sv
// Directed and randomized checks of t_subtractor against an arithmetic reference model.
module tb_t_subtractor;

  logic       clk;
  logic       rst;
  logic       start_i;
  logic [7:0] c_i;
  logic [3:0] a_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] diff_o;
  logic [3:0] b_o;
  logic       neg_o;
  logic       ovf_o;
  logic [1:0] dbg_state;

  int total;
  int bad;
  int cyc;
  int done_cnt;
  int done_t[$];
  logic [13:0] exp_q[$];

  localparam logic [1:0] ST_IDLE = 2'd0;

  t_subtractor dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .c_i       (c_i),
    .a_i       (a_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .diff_o    (diff_o),
    .b_o       (b_o),
    .neg_o     (neg_o),
    .ovf_o     (ovf_o),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // done monitor: counts strobes and records the cycle each one was seen
  initial begin
    cyc = 0;
    done_cnt = 0;
  end
  always @(posedge clk) begin
    cyc++;
    if (done_o === 1'b1) begin
      done_cnt++;
      done_t.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: plain modular arithmetic
  function automatic logic [13:0] model(input logic [7:0] c, input logic [3:0] a);
    int d;
    logic [7:0] diff;
    logic neg;
    logic ovf;
    d    = int'(c) - int'(a);
    neg  = (d < 0);
    diff = 8'((d + 256) % 256);
    ovf  = !neg && (d > 15);
    return {diff, diff[3:0], neg, ovf};
  endfunction

  // driver: one start pulse, inputs scrambled while the operation runs
  task automatic do_op(input string tag, input logic [7:0] c, input logic [3:0] a, input bit full);
    int n;
    int busy_n;
    logic [7:0] diff_hold;
    exp_q.push_back(model(c, a));
    @(negedge clk);
    c_i = c;
    a_i = a;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 1;
    busy_n = 0;
    while (done_o !== 1'b1 && n < 20) begin
      if (busy_o === 1'b1) busy_n++;
      c_i = 8'($urandom);
      a_i = 4'($urandom);
      @(negedge clk);
      n++;
    end
    chk({tag, "_result"}, {18'd0, diff_o, b_o, neg_o, ovf_o}, {18'd0, exp_q.pop_front()});
    if (full) begin
      chk({tag, "_latency"}, n, 9);
      chk({tag, "_busy_cycles"}, busy_n, 8);
      chk({tag, "_neg_ovf_excl"}, {31'd0, neg_o & ovf_o}, 0);
      diff_hold = diff_o;
      @(negedge clk);
      chk({tag, "_done_drop"}, {31'd0, done_o}, 0);
      chk({tag, "_idle_after"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
      chk({tag, "_diff_hold"}, {24'd0, diff_o}, {24'd0, diff_hold});
    end
  endtask

  initial begin
    int base;
    logic [7:0] rc;
    logic [3:0] ra;
    total = 0;
    bad = 0;
    rst = 1'b1;
    start_i = 1'b0;
    c_i = 8'd0;
    a_i = 4'd0;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", {18'd0, busy_o, done_o, diff_o, b_o, neg_o, ovf_o}, 0);
    chk("reset_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    rst = 1'b0;

    // nominal case with explicit constants as well as the model
    do_op("nominal", 8'h12, 4'd5, 1'b1);
    chk("nominal_diff", {24'd0, diff_o}, 32'h0D);
    chk("nominal_b", {28'd0, b_o}, 32'hD);
    chk("nominal_flags", {30'd0, neg_o, ovf_o}, 0);

    do_op("underflow", 8'h03, 4'd5, 1'b1);
    chk("underflow_const", {18'd0, diff_o, b_o, neg_o, ovf_o}, {18'd0, 8'hFE, 4'hE, 1'b1, 1'b0});
    do_op("max_in_range", 8'h1E, 4'hF, 1'b1);
    chk("max_in_range_const", {25'd0, b_o, neg_o, ovf_o}, {25'd0, 4'hF, 1'b0, 1'b0});
    do_op("overflow", 8'h20, 4'd0, 1'b1);
    chk("overflow_const", {18'd0, diff_o, b_o, neg_o, ovf_o}, {18'd0, 8'h20, 4'h0, 1'b0, 1'b1});
    do_op("c0_a15", 8'h00, 4'hF, 1'b1);
    chk("c0_a15_const", {22'd0, diff_o, neg_o, ovf_o}, {22'd0, 8'hF1, 1'b1, 1'b0});
    do_op("c_eq_a", 8'h09, 4'h9, 1'b1);
    chk("c_eq_a_const", {22'd0, diff_o, neg_o, ovf_o}, 0);
    rc = 8'($urandom);
    do_op("a_zero", rc, 4'd0, 1'b1);
    chk("a_zero_const", {24'd0, diff_o}, {24'd0, rc});

    // input stability and ignored starts in RUN and DONE
    base = done_cnt;
    @(negedge clk);
    c_i = 8'h12;
    a_i = 4'd5;
    start_i = 1'b1;
    @(negedge clk);
    c_i = 8'hFF;
    for (int n = 1; n <= 9; n++) begin
      start_i = (n == 3 || n == 8 || n == 9);
      if (n == 9) begin
        chk("ignore_done_high", {31'd0, done_o}, 1);
        chk("ignore_diff", {24'd0, diff_o}, 32'h0D);
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    chk("ignore_idle_after", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    repeat (12) @(negedge clk);
    chk("ignore_one_done", done_cnt - base, 1);

    // reset during RUN aborts the operation
    @(negedge clk);
    c_i = 8'h55;
    a_i = 4'd3;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    base = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outputs", {18'd0, busy_o, done_o, diff_o, b_o, neg_o, ovf_o}, 0);
    chk("abort_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    repeat (12) @(negedge clk);
    chk("abort_no_done", done_cnt - base, 0);
    do_op("after_abort", 8'h1E, 4'hF, 1'b1);

    // back-to-back with start held high for 25 cycles
    base = done_cnt;
    done_t.delete();
    @(negedge clk);
    c_i = 8'h37;
    a_i = 4'd9;
    start_i = 1'b1;
    repeat (25) @(negedge clk);
    start_i = 1'b0;
    repeat (15) @(negedge clk);
    chk("b2b_count", done_cnt - base, 3);
    if (done_t.size() >= 3) begin
      chk("b2b_gap1", done_t[1] - done_t[0], 10);
      chk("b2b_gap2", done_t[2] - done_t[1], 10);
    end else begin
      chk("b2b_times", done_t.size(), 3);
    end
    chk("b2b_result", {18'd0, diff_o, b_o, neg_o, ovf_o}, {18'd0, model(8'h37, 4'd9)});

    // randomized operands
    for (int i = 0; i < 40; i++) begin
      rc = 8'($urandom_range(0, 255));
      ra = 4'($urandom_range(0, 15));
      do_op("random", rc, ra, (i % 8) == 0);
    end

    // exhaustive sweep of all operand pairs
    for (int c = 0; c < 256; c++) begin
      for (int a = 0; a < 16; a++) begin
        do_op("sweep", 8'(c), 4'(a), 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
